logic_unit_pipe: RTL and testbench
==================================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, pipelined bitwise logic unit replacing the fixed 32-bit single-op XOR stage in the ALUOP group.
//  Performs one of eight bitwise ops on WIDTH-bit operands and returns zero and parity flags.
//  Optional accumulate mode substitutes the internal accumulator for operand A (running XOR checksums, masks).
//  Sits between ALU operand select and the writeback mux, with valid/ready handshakes on both sides.
// PARAMETERS
//  WIDTH      32   operand/result width in bits (>=1)
//  ACC_RESET  0    accumulator value after reset and after acc_clr (WIDTH bits)
// PORTS
//  clk        in   1      system clock; all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      request valid
//  in_ready   out  1      unit can accept a request this cycle
//  in_op      in   3      000 AND, 001 OR, 010 XOR, 011 NOR, 100 XNOR, 101 ANDN(a&~b), 110 PASSB, 111 NOTB
//  in_a       in   WIDTH  operand A (ignored when in_acc=1)
//  in_b       in   WIDTH  operand B
//  in_acc     in   1      use accumulator as A; write result back into accumulator
//  acc_clr    in   1      reset accumulator to ACC_RESET (independent of handshake)
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result this cycle
//  out_data   out  WIDTH  result
//  out_zero   out  1      out_data == 0
//  out_parity out  1      XOR-reduction of out_data
//  acc_value  out  WIDTH  current accumulator contents
// BEHAVIOUR
//  - Reset (async assert, sync release): out_valid=0, out_data=0, out_zero=0, out_parity=0, acc=ACC_RESET,
//    skid empty, in_ready=1. Asserting reset mid-operation drops both held results; nothing is replayed.
//  - Accept: in_valid & in_ready. Consume: out_valid & out_ready. Latency 1 cycle from accept to out_valid.
//  - Storage: output register plus one skid register. in_ready = !skid_valid, driven from a register with no
//    combinational path from out_ready.
//  - On accept: the result loads the output register if it is empty or consumed this cycle. Otherwise it loads
//    the skid register.
//  - On consume with skid full: skid moves to the output register. out_valid stays 1. in_ready returns to 1
//    next cycle.
//  - Held outputs (data, flags) stay stable while out_valid=1 and out_ready=0.
//  - Order is strictly FIFO. Throughput is 1 op/cycle while out_ready stays high.
//  - Flags are computed from the result and stored with it. out_zero and out_parity always match out_data.
//  - A source = in_acc ? acc : in_a. PASSB and NOTB ignore A.
//  - Accumulator update: on an accepted in_acc=1 op, acc <= result (same edge). in_acc=0 ops leave acc unchanged.
//  - Back-to-back acc ops use the updated acc with no bubble; the acc bypass is internal.
//  - acc_clr: acc <= ACC_RESET next edge.
//  - acc_clr with an accepted acc op in the same cycle: clear applies first. The op uses A=ACC_RESET, and acc
//    takes that op's result.
//  - acc_value reflects the registered acc, observable one cycle after update.
//  - in_valid is sampled only when in_ready=1. Inputs are don't-care otherwise; nothing is lost or duplicated.
//  - Undefined in_op cannot occur (3-bit code, full decode).
// TESTING
//  1. WIDTH=32, XOR a=0xFFFF0000 b=0x0F0F0F0F, out_ready=1
//     -> next cycle out_data=0xF0F00F0F, out_zero=0, out_parity=0.
//  2. All 8 ops with a=0xA5A5A5A5 b=0x0000FFFF -> AND 0x0000A5A5, NOR 0x5A5A0000,
//     ANDN 0xA5A50000, NOTB 0xFFFF0000, etc.; XOR a=b -> out_zero=1.
//  3. Back-pressure: 4 back-to-back requests, out_ready=0 -> 2 accepted, in_ready=0 from cycle 2;
//     release out_ready -> 4 results in order, none dropped or duplicated.
//  4. Accumulate: acc_clr, then XOR in_acc=1 with b=0x1,0x2,0x4 on consecutive cycles
//     -> results 0x1,0x3,0x7; acc_value=0x7.
//  5. acc_clr with accepted acc OR b=0x10 while acc=0xFF -> result 0x10, acc=0x10.
//  6. rst_n low with both entries full -> immediate out_valid=0, in_ready=1, acc=ACC_RESET;
//     WIDTH=8 rerun of scenarios 1 and 4.

Source files
------------

// File: rtl/logic_unit_if.sv
// Request/result bundle for logic_unit_pipe: request handshake, accumulator control,
// and the result handshake with its stored flags.
interface logic_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_acc;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_parity;
    logic [WIDTH-1:0] acc_value;

    modport master (
        output in_valid, in_op, in_a, in_b, in_acc, acc_clr, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_parity, acc_value
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_acc, acc_clr, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_parity, acc_value
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: eight ops, zero/parity flags, optional accumulator as operand A,
// one-cycle latency with an output register plus a skid register for full throughput.
module logic_unit_pipe #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
    input logic          clk,
    input logic          rst_n,
    logic_unit_if.slave  bus
);

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_NOR   = 3'b011;
    localparam logic [2:0] OP_XNOR  = 3'b100;
    localparam logic [2:0] OP_ANDN  = 3'b101;
    localparam logic [2:0] OP_PASSB = 3'b110;

    function automatic logic [WIDTH-1:0] logic_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NOR:   r = ~(a | b);
            OP_XNOR:  r = ~(a ^ b);
            OP_ANDN:  r = a & ~b;
            OP_PASSB: r = b;
            default:  r = ~b;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_src_p0;
    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] res_p0;
    logic             zero_p0;
    logic             par_p0;
    logic             accept;
    logic             consume;

    logic             vld_p1;
    logic [WIDTH-1:0] data_p1;
    logic             zero_p1;
    logic             par_p1;
    logic             skid_vld_p1;
    logic [WIDTH-1:0] skid_data_p1;
    logic             skid_zero_p1;
    logic             skid_par_p1;

    // Stage p0: operand select and compute; a same-cycle clear is folded in ahead of the op
    assign acc_src_p0 = bus.acc_clr ? ACC_RESET : acc_q;
    assign a_p0       = bus.in_acc ? acc_src_p0 : bus.in_a;
    assign res_p0     = logic_op(bus.in_op, a_p0, bus.in_b);
    assign zero_p0    = ~|res_p0;
    assign par_p0     = ^res_p0;

    assign accept  = bus.in_valid & ~skid_vld_p1;
    assign consume = vld_p1 & bus.out_ready;

    // Stage p1: output register plus skid; skid is only ever filled while the output register is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1       <= 1'b0;
            data_p1      <= '0;
            zero_p1      <= 1'b0;
            par_p1       <= 1'b0;
            skid_vld_p1  <= 1'b0;
            skid_data_p1 <= '0;
            skid_zero_p1 <= 1'b0;
            skid_par_p1  <= 1'b0;
            acc_q        <= ACC_RESET;
        end else begin
            if (consume) begin
                if (skid_vld_p1) begin
                    data_p1     <= skid_data_p1;
                    zero_p1     <= skid_zero_p1;
                    par_p1      <= skid_par_p1;
                    skid_vld_p1 <= 1'b0;
                end else if (accept) begin
                    data_p1 <= res_p0;
                    zero_p1 <= zero_p0;
                    par_p1  <= par_p0;
                end else begin
                    vld_p1 <= 1'b0;
                end
            end else if (accept) begin
                if (!vld_p1) begin
                    vld_p1  <= 1'b1;
                    data_p1 <= res_p0;
                    zero_p1 <= zero_p0;
                    par_p1  <= par_p0;
                end else begin
                    skid_vld_p1  <= 1'b1;
                    skid_data_p1 <= res_p0;
                    skid_zero_p1 <= zero_p0;
                    skid_par_p1  <= par_p0;
                end
            end

            if (accept && bus.in_acc) begin
                acc_q <= res_p0;
            end else if (bus.acc_clr) begin
                acc_q <= ACC_RESET;
            end
        end
    end

    assign bus.in_ready   = ~skid_vld_p1;
    assign bus.out_valid  = vld_p1;
    assign bus.out_data   = data_p1;
    assign bus.out_zero   = zero_p1;
    assign bus.out_parity = par_p1;
    assign bus.acc_value  = acc_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe: a 32-bit and an 8-bit instance sharing clock and reset,
// one task per scenario with hand-computed expected values.
module tb_logic_unit_pipe;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic_unit_if #(.WIDTH(32)) bus32();
    logic_unit_if #(.WIDTH(8))  bus8();

    logic_unit_pipe #(.WIDTH(32), .ACC_RESET(32'h0)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    logic_unit_pipe #(.WIDTH(8),  .ACC_RESET(8'h0))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    localparam logic [2:0] AND_OP = 3'd0, OR_OP = 3'd1, XOR_OP = 3'd2, PASSB_OP = 3'd6;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle32();
        bus32.in_valid = 1'b0; bus32.in_acc = 1'b0; bus32.acc_clr = 1'b0; bus32.out_ready = 1'b1;
        bus32.in_op = 3'd0; bus32.in_a = '0; bus32.in_b = '0;
    endtask

    task automatic idle8();
        bus8.in_valid = 1'b0; bus8.in_acc = 1'b0; bus8.acc_clr = 1'b0; bus8.out_ready = 1'b1;
        bus8.in_op = 3'd0; bus8.in_a = '0; bus8.in_b = '0;
    endtask

    task automatic put32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic acc);
        bus32.in_valid = 1'b1; bus32.in_op = op; bus32.in_a = a; bus32.in_b = b; bus32.in_acc = acc;
    endtask

    task automatic put8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic acc);
        bus8.in_valid = 1'b1; bus8.in_op = op; bus8.in_a = a; bus8.in_b = b; bus8.in_acc = acc;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle32();
        idle8();
        #12;
        checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus32.out_valid); end
        checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus32.in_ready); end
        checks++; if (bus32.out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", bus32.out_data); end
        checks++; if (bus32.out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero: got %b expected 0", bus32.out_zero); end
        checks++; if (bus32.acc_value !== 32'h0) begin errors++; $display("FAIL reset_acc: got %h expected 0", bus32.acc_value); end
        checks++; if (bus8.out_valid !== 1'b0) begin errors++; $display("FAIL reset8_out_valid: got %b expected 0", bus8.out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_xor32();
        put32(XOR_OP, 32'hFFFF0000, 32'h0F0F0F0F, 1'b0);
        cyc();
        bus32.in_valid = 1'b0;
        checks++; if (bus32.out_valid !== 1'b1) begin errors++; $display("FAIL xor_valid: got %b expected 1", bus32.out_valid); end
        checks++; if (bus32.out_data !== 32'hF0F00F0F) begin errors++; $display("FAIL xor_data: got %h expected F0F00F0F", bus32.out_data); end
        checks++; if (bus32.out_zero !== 1'b0) begin errors++; $display("FAIL xor_zero: got %b expected 0", bus32.out_zero); end
        checks++; if (bus32.out_parity !== 1'b0) begin errors++; $display("FAIL xor_parity: got %b expected 0", bus32.out_parity); end
        cyc();
        checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL xor_drained: got %b expected 0", bus32.out_valid); end
    endtask

    task automatic test_all_ops();
        logic [31:0] exp_ops [8] = '{32'h0000A5A5, 32'hA5A5FFFF, 32'hA5A55A5A, 32'h5A5A0000,
                                     32'h5A5AA5A5, 32'hA5A50000, 32'h0000FFFF, 32'hFFFF0000};
        for (int i = 0; i < 8; i++) begin
            put32(3'(i), 32'hA5A5A5A5, 32'h0000FFFF, 1'b0);
            cyc();
            checks++; if (bus32.out_data !== exp_ops[i]) begin errors++; $display("FAIL op%0d_data: got %h expected %h", i, bus32.out_data, exp_ops[i]); end
            checks++; if (bus32.out_valid !== 1'b1) begin errors++; $display("FAIL op%0d_valid: got %b expected 1", i, bus32.out_valid); end
        end
        put32(XOR_OP, 32'h12345678, 32'h12345678, 1'b0);
        cyc();
        checks++; if (bus32.out_zero !== 1'b1) begin errors++; $display("FAIL xor_eq_zero: got %b expected 1", bus32.out_zero); end
        checks++; if (bus32.out_data !== 32'h0) begin errors++; $display("FAIL xor_eq_data: got %h expected 0", bus32.out_data); end
        put32(XOR_OP, 32'h00000001, 32'h00000000, 1'b0);
        cyc();
        checks++; if (bus32.out_parity !== 1'b1) begin errors++; $display("FAIL odd_parity: got %b expected 1", bus32.out_parity); end
        checks++; if (bus32.out_zero !== 1'b0) begin errors++; $display("FAIL odd_zero: got %b expected 0", bus32.out_zero); end
        idle32();
        cyc();
    endtask

    task automatic test_back_pressure();
        logic [31:0] vals [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        logic [31:0] got [$];
        int idx = 2;
        logic will_acc;
        bus32.out_ready = 1'b0;
        checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0: got %b expected 1", bus32.in_ready); end
        put32(PASSB_OP, 32'h0, vals[0], 1'b0);
        cyc();
        checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b expected 1", bus32.in_ready); end
        checks++; if (bus32.out_data !== 32'h11) begin errors++; $display("FAIL bp_first: got %h expected 11", bus32.out_data); end
        put32(PASSB_OP, 32'h0, vals[1], 1'b0);
        cyc();
        checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready2: got %b expected 0", bus32.in_ready); end
        put32(PASSB_OP, 32'h0, vals[2], 1'b0);
        cyc();
        checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready3: got %b expected 0", bus32.in_ready); end
        checks++; if (bus32.out_data !== 32'h11 || bus32.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold: got %h/%b expected 11/1", bus32.out_data, bus32.out_valid); end
        bus32.out_ready = 1'b1;
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            bus32.in_valid = (idx < 4);
            if (idx < 4) bus32.in_b = vals[idx];
            will_acc = bus32.in_valid && bus32.in_ready;
            if (bus32.out_valid && bus32.out_ready) got.push_back(bus32.out_data);
            cyc();
            if (will_acc) idx++;
        end
        idle32();
        checks++; if (got.size() != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", got.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                checks++; if (got[i] !== vals[i]) begin errors++; $display("FAIL bp_order%0d: got %h expected %h", i, got[i], vals[i]); end
            end
        end
        cyc();
        checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b expected 0", bus32.out_valid); end
    endtask

    task automatic test_accumulate();
        logic [31:0] bs [3] = '{32'h1, 32'h2, 32'h4};
        logic [31:0] rs [3] = '{32'h1, 32'h3, 32'h7};
        put32(PASSB_OP, 32'h0, 32'h5555, 1'b1);
        cyc();
        idle32();
        bus32.acc_clr = 1'b1;
        cyc();
        bus32.acc_clr = 1'b0;
        checks++; if (bus32.acc_value !== 32'h0) begin errors++; $display("FAIL acc_clr: got %h expected 0", bus32.acc_value); end
        for (int i = 0; i < 3; i++) begin
            put32(XOR_OP, 32'hDEADBEEF, bs[i], 1'b1);
            cyc();
            checks++; if (bus32.out_data !== rs[i]) begin errors++; $display("FAIL acc_step%0d: got %h expected %h", i, bus32.out_data, rs[i]); end
        end
        idle32();
        checks++; if (bus32.acc_value !== 32'h7) begin errors++; $display("FAIL acc_value: got %h expected 7", bus32.acc_value); end
        cyc();
    endtask

    task automatic test_clr_with_acc();
        put32(PASSB_OP, 32'h0, 32'hFF, 1'b1);
        cyc();
        checks++; if (bus32.acc_value !== 32'hFF) begin errors++; $display("FAIL preload_acc: got %h expected FF", bus32.acc_value); end
        put32(OR_OP, 32'h0, 32'h10, 1'b1);
        bus32.acc_clr = 1'b1;
        cyc();
        bus32.acc_clr = 1'b0;
        checks++; if (bus32.out_data !== 32'h10) begin errors++; $display("FAIL clr_op_data: got %h expected 10", bus32.out_data); end
        checks++; if (bus32.acc_value !== 32'h10) begin errors++; $display("FAIL clr_op_acc: got %h expected 10", bus32.acc_value); end
        put32(XOR_OP, 32'h3, 32'h5, 1'b0);
        cyc();
        checks++; if (bus32.out_data !== 32'h6) begin errors++; $display("FAIL nonacc_data: got %h expected 6", bus32.out_data); end
        checks++; if (bus32.acc_value !== 32'h10) begin errors++; $display("FAIL nonacc_acc: got %h expected 10", bus32.acc_value); end
        idle32();
        cyc();
    endtask

    task automatic test_reset_midop();
        bus32.out_ready = 1'b0;
        put32(PASSB_OP, 32'h0, 32'hAA, 1'b0);
        cyc();
        put32(PASSB_OP, 32'h0, 32'hBB, 1'b0);
        cyc();
        bus32.in_valid = 1'b0;
        checks++; if (bus32.in_ready !== 1'b0) begin errors++; $display("FAIL midop_full: got %b expected 0", bus32.in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL midop_valid: got %b expected 0", bus32.out_valid); end
        checks++; if (bus32.in_ready !== 1'b1) begin errors++; $display("FAIL midop_ready: got %b expected 1", bus32.in_ready); end
        checks++; if (bus32.acc_value !== 32'h0) begin errors++; $display("FAIL midop_acc: got %h expected 0", bus32.acc_value); end
        checks++; if (bus32.out_data !== 32'h0) begin errors++; $display("FAIL midop_data: got %h expected 0", bus32.out_data); end
        @(negedge clk);
        rst_n = 1'b1;
        idle32();
        cyc();
        checks++; if (bus32.out_valid !== 1'b0) begin errors++; $display("FAIL midop_no_replay: got %b expected 0", bus32.out_valid); end
        put32(XOR_OP, 32'h0, 32'h1, 1'b0);
        cyc();
        checks++; if (bus32.out_data !== 32'h1) begin errors++; $display("FAIL post_reset_op: got %h expected 1", bus32.out_data); end
        idle32();
        cyc();
    endtask

    task automatic test_w8_xor();
        put8(XOR_OP, 8'hFF, 8'h0E, 1'b0);
        cyc();
        bus8.in_valid = 1'b0;
        checks++; if (bus8.out_data !== 8'hF1) begin errors++; $display("FAIL w8_xor_data: got %h expected F1", bus8.out_data); end
        checks++; if (bus8.out_parity !== 1'b1) begin errors++; $display("FAIL w8_xor_parity: got %b expected 1", bus8.out_parity); end
        checks++; if (bus8.out_zero !== 1'b0) begin errors++; $display("FAIL w8_xor_zero: got %b expected 0", bus8.out_zero); end
        cyc();
    endtask

    task automatic test_w8_accumulate();
        logic [7:0] bs [4] = '{8'h01, 8'h02, 8'h04, 8'h80};
        logic [7:0] rs [4] = '{8'h01, 8'h03, 8'h07, 8'h87};
        bus8.acc_clr = 1'b1;
        cyc();
        bus8.acc_clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put8(XOR_OP, 8'h5A, bs[i], 1'b1);
            cyc();
            checks++; if (bus8.out_data !== rs[i]) begin errors++; $display("FAIL w8_acc_step%0d: got %h expected %h", i, bus8.out_data, rs[i]); end
        end
        idle8();
        checks++; if (bus8.acc_value !== 8'h87) begin errors++; $display("FAIL w8_acc_value: got %h expected 87", bus8.acc_value); end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_xor32();
        test_all_ops();
        test_back_pressure();
        test_accumulate();
        test_clr_with_acc();
        test_reset_midop();
        test_w8_xor();
        test_w8_accumulate();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
